// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter sharing one physical memory port between an I-cache and a D-cache.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              i_pend, d_pend, grant_i, grant_d;

  assign i_pend  = i_pmem_read;
  assign d_pend  = d_pmem_read | d_pmem_write;
  // last_grant_q is 1 when D was granted last, so a tie goes to I.
  assign grant_i = (state_q == IDLE) & i_pend & (~d_pend | last_grant_q);
  assign grant_d = (state_q == IDLE) & d_pend & (~i_pend | ~last_grant_q);

  // Arbitrate in IDLE, latch the winner's command, leave SERVE on memory completion.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    if (grant_i) begin
      state_d      = SERVE_I;
      last_grant_d = 1'b0;
      addr_d       = i_pmem_address;
      write_d      = 1'b0;
    end else if (grant_d) begin
      state_d      = SERVE_D;
      last_grant_d = 1'b1;
      addr_d       = d_pmem_address;
      write_d      = d_pmem_write;
      wdata_d      = d_pmem_wdata;
    end else if (state_q != IDLE && pmem_resp) begin
      state_d = IDLE;
    end
  end

  // State and latched command registers; reset drops any outstanding transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
    end
  end

  // Memory commands come only from latched registers; completions route to the owner.
  always_comb begin
    pmem_read    = (state_q == SERVE_I) | ((state_q == SERVE_D) & ~write_q);
    pmem_write   = (state_q == SERVE_D) & write_q;
    pmem_address = (state_q == IDLE) ? '0 : addr_q;
    pmem_wdata   = (state_q == SERVE_D) ? wdata_q : '0;
    i_pmem_resp  = (state_q == SERVE_I) & pmem_resp;
    d_pmem_resp  = (state_q == SERVE_D) & pmem_resp;
    i_pmem_rdata = pmem_rdata;
    d_pmem_rdata = pmem_rdata;
  end
endmodule
